// File: rtl/flash_cmd_engine.sv
// rtl/flash_cmd_engine.sv - read/program/erase command sequencer for a 16-bit parallel flash
// Define FLASH_TIMEOUT_EN to bound status polling to TIMEOUT_POLLS reads.
module flash_cmd_engine #(
   parameter int WAIT_CYCLES   = 4,
   parameter int TIMEOUT_POLLS = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [21:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [22:0] flash_addr,
   inout  wire  [15:0] flash_data,
   output logic [7:0]  flash_ctl
);

   typedef enum logic [2:0] {IDLE, WR_LOW, WR_HIGH, RD, RD_GAP} phase_t;
   typedef enum logic [2:0] {ST_RDCMD, ST_READ, ST_CMD1, ST_CMD2, ST_POLLCMD, ST_POLL, ST_CLEAR} step_t;

   localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be 1..15");
   end
   if (TIMEOUT_POLLS < 1 || TIMEOUT_POLLS > 1023) begin : g_bad_polls
      $error("TIMEOUT_POLLS must be 1..1023");
   end

   phase_t      phase;
   step_t       step;
   logic [3:0]  cnt;
   logic        is_prog;
   logic [15:0] wdata_q;
   logic [15:0] wr_data;
   logic [15:0] rd_word;
   logic        we_n;
   logic        oe_n;
   logic        drive;
   logic        poll_expired;
   logic        poll_done;
   logic        poll_err;

`ifdef FLASH_TIMEOUT_EN
   logic [9:0]  poll_cnt;
   assign poll_expired = (poll_cnt == 10'(TIMEOUT_POLLS - 1));
`else
   assign poll_expired = 1'b0;
`endif

   // A ready status reports its own error bits; a timed-out poll is always an error.
   assign poll_done = rd_word[7] | poll_expired;
   assign poll_err  = rd_word[7] ? (rd_word[5] | rd_word[4] | rd_word[3] | rd_word[1]) : 1'b1;

   assign flash_ctl  = {we_n, 1'b1, 1'b1, oe_n, 1'b0, 1'b0, 1'b0, 1'b1};
   assign flash_data = drive ? wr_data : 16'hzzzz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase      <= IDLE;
         step       <= ST_RDCMD;
         cnt        <= '0;
         is_prog    <= 1'b0;
         wdata_q    <= '0;
         wr_data    <= '0;
         rd_word    <= '0;
         we_n       <= 1'b1;
         oe_n       <= 1'b1;
         drive      <= 1'b0;
         flash_addr <= '0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
`ifdef FLASH_TIMEOUT_EN
         poll_cnt   <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (phase)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  if (req_op == 2'b11) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     flash_addr <= {req_addr, 1'b0};
                     is_prog    <= (req_op == 2'b01);
                     wdata_q    <= req_wdata;
                     step       <= (req_op == 2'b00) ? ST_RDCMD : ST_CMD1;
                     case (req_op)
                        2'b00:   wr_data <= 16'h00FF;
                        2'b01:   wr_data <= 16'h0040;
                        default: wr_data <= 16'h0020;
                     endcase
                     phase <= WR_LOW;
                     we_n  <= 1'b0;
                     drive <= 1'b1;
                     cnt   <= RELOAD;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WR_LOW: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  phase <= WR_HIGH;
                  we_n  <= 1'b1;
                  cnt   <= RELOAD;
               end
            end
            WR_HIGH: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  cnt <= RELOAD;
                  case (step)
                     ST_RDCMD, ST_POLLCMD: begin
                        phase <= RD;
                        oe_n  <= 1'b0;
                        drive <= 1'b0;
                        step  <= (step == ST_RDCMD) ? ST_READ : ST_POLL;
`ifdef FLASH_TIMEOUT_EN
                        poll_cnt <= '0;
`endif
                     end
                     ST_CMD1: begin
                        phase   <= WR_LOW;
                        we_n    <= 1'b0;
                        wr_data <= is_prog ? wdata_q : 16'h00D0;
                        step    <= ST_CMD2;
                     end
                     ST_CMD2: begin
                        phase   <= WR_LOW;
                        we_n    <= 1'b0;
                        wr_data <= 16'h0070;
                        step    <= ST_POLLCMD;
                     end
                     default: begin
                        phase     <= IDLE;
                        drive     <= 1'b0;
                        rsp_valid <= 1'b1;
                     end
                  endcase
               end
            end
            RD: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rd_word <= flash_data;
                  oe_n    <= 1'b1;
                  phase   <= RD_GAP;
               end
            end
            RD_GAP: begin
               cnt <= RELOAD;
               if (step == ST_READ) begin
                  phase     <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd_word;
                  rsp_err   <= 1'b0;
               end else if (poll_done) begin
                  rsp_rdata <= rd_word;
                  rsp_err   <= poll_err;
                  wr_data   <= 16'h00FF;
                  step      <= ST_CLEAR;
                  phase     <= WR_LOW;
                  we_n      <= 1'b0;
                  drive     <= 1'b1;
               end else begin
                  phase <= RD;
                  oe_n  <= 1'b0;
`ifdef FLASH_TIMEOUT_EN
                  poll_cnt <= poll_cnt + 10'd1;
`endif
               end
            end
            default: phase <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_cmd_engine.sv
// tb/tb_flash_cmd_engine.sv - self-checking bench for flash_cmd_engine with a behavioural flash device
// Timeout scenario runs only when FLASH_TIMEOUT_EN is defined.
module tb_flash_cmd_engine;
   localparam int WAIT = 4;
   localparam int TMO  = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [21:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [22:0] flash_addr;
   wire  [15:0] flash_data;
   logic [7:0]  flash_ctl;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   flash_cmd_engine #(.WAIT_CYCLES(WAIT), .TIMEOUT_POLLS(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .flash_addr (flash_addr),
      .flash_data (flash_data),
      .flash_ctl  (flash_ctl)
   );

   // Device: 0xFF selects array mode, any other command selects status mode.
   logic        array_mode = 1'b1;
   int          st_reads = 0;
   logic [15:0] array_word = '0;
   logic [15:0] busy_word = '0;
   logic [15:0] final_status = 16'h0080;
   int          busy_reads = 0;
   logic [22:0] array_addr = '0;
   logic [15:0] dev_out;

   assign dev_out = array_mode ? ((flash_addr == array_addr) ? array_word : 16'hDEAD)
                               : ((st_reads < busy_reads) ? busy_word : final_status);
   assign flash_data = (flash_ctl[4] == 1'b0) ? dev_out : 16'hzzzz;

   logic [38:0] wr_log[$];
   int          we_runs[$];
   int          oe_runs[$];
   int          we_run = 0;
   int          oe_run = 0;
   int          reads_total = 0;
   int          rsp_total = 0;
   int          violations = 0;
   logic        prev_we = 1'b1;
   logic        prev_oe = 1'b1;

   always @(negedge clk) begin
      if (flash_ctl[7] === 1'b0 && flash_ctl[4] === 1'b0) violations++;
      if ({flash_ctl[6:5], flash_ctl[3:0]} !== 6'b11_0001) violations++;
      if (flash_ctl[7] === 1'b0) begin
         we_run++;
      end else if (prev_we === 1'b0) begin
         wr_log.push_back({flash_addr, flash_data});
         we_runs.push_back(we_run);
         we_run = 0;
         array_mode = (flash_data === 16'h00FF);
         if (flash_data === 16'h0070) st_reads = 0;
      end
      if (flash_ctl[4] === 1'b0) begin
         oe_run++;
      end else if (prev_oe === 1'b0) begin
         oe_runs.push_back(oe_run);
         oe_run = 0;
         reads_total++;
         st_reads++;
      end
      if (rsp_valid === 1'b1) rsp_total++;
      prev_we = flash_ctl[7];
      prev_oe = flash_ctl[4];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   logic [15:0] exp_wr[$];
   int          exp_reads;
   int          exp_lat;
   logic [15:0] exp_rd;
   logic        exp_err;

   task automatic model(input logic [1:0] op, input logic [15:0] wd);
      int          polls;
      logic [15:0] status;
      logic        timed;
      exp_wr = {};
      case (op)
         2'b00: begin
            exp_wr.push_back(16'h00FF);
            exp_reads = 1;
            exp_rd    = array_word;
            exp_err   = 1'b0;
         end
         2'b11: begin
            exp_reads = 0;
            exp_rd    = 16'h0000;
            exp_err   = 1'b1;
         end
         default: begin
            exp_wr.push_back(op == 2'b01 ? 16'h0040 : 16'h0020);
            exp_wr.push_back(op == 2'b01 ? wd : 16'h00D0);
            exp_wr.push_back(16'h0070);
            exp_wr.push_back(16'h00FF);
            polls  = busy_reads + 1;
            status = final_status;
            timed  = 1'b0;
`ifdef FLASH_TIMEOUT_EN
            if (polls > TMO) begin
               polls  = TMO;
               status = busy_word;
               timed  = 1'b1;
            end
`endif
            exp_reads = polls;
            exp_rd    = status;
            exp_err   = timed | status[5] | status[4] | status[3] | status[1];
         end
      endcase
      exp_lat = exp_wr.size() * 2 * WAIT + exp_reads * (WAIT + 1);
   endtask

   task automatic run_cmd(input string name, input logic [1:0] op, input logic [21:0] addr,
                          input logic [15:0] wd);
      int          w0;
      int          we0;
      int          oe0;
      int          r0;
      int          lat;
      int          bad;
      logic        got;
      logic        rdy_rsp;
      logic        val_next;
      logic        rdy_next;
      logic [15:0] rd;
      logic        er;
      model(op, wd);
      array_addr = {addr, 1'b0};
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (req_ready === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      check({name, " ready"}, 64'(got), 64'd1);
      w0  = wr_log.size();
      we0 = we_runs.size();
      oe0 = oe_runs.size();
      r0  = reads_total;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      @(negedge clk);
      lat = 0;
      got = 1'b0;
      while (!got && lat <= exp_lat + 20) begin
         if (rsp_valid === 1'b1) begin
            got = 1'b1;
         end else begin
            req_valid = 1'b1;
            req_op    = 2'($urandom);
            req_addr  = 22'($urandom);
            req_wdata = 16'($urandom);
            @(negedge clk);
            lat++;
         end
      end
      req_valid = 1'b0;
      rd      = rsp_rdata;
      er      = rsp_err;
      rdy_rsp = req_ready;
      @(negedge clk);
      val_next = rsp_valid;
      rdy_next = req_ready;
      check({name, " rsp seen"}, 64'(got), 64'd1);
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " rdata"}, 64'(rd), 64'(exp_rd));
      check({name, " err"}, 64'(er), 64'(exp_err));
      check({name, " handshake"}, 64'({rdy_rsp, val_next, rdy_next}), 64'(3'b001));
      check({name, " writes"}, 64'(wr_log.size() - w0), 64'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && w0 + i < wr_log.size(); i++)
         check($sformatf("%s wr%0d", name, i), 64'(wr_log[w0 + i]), 64'({array_addr, exp_wr[i]}));
      check({name, " reads"}, 64'(reads_total - r0), 64'(exp_reads));
      bad = 0;
      for (int i = we0; i < we_runs.size(); i++) if (we_runs[i] != WAIT) bad++;
      for (int i = oe0; i < oe_runs.size(); i++) if (oe_runs[i] != WAIT) bad++;
      check({name, " phase widths"}, 64'(bad), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          r0;
      logic [21:0] er_addr;
      logic [1:0]  op;
      logic [21:0] addr;
      logic [15:0] wd;

      repeat (2) @(negedge clk);
      check("reset req_ready", 64'(req_ready), 64'd0);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_err", 64'(rsp_err), 64'd0);
      check("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("reset flash_addr", 64'(flash_addr), 64'd0);
      check("reset flash_ctl", 64'(flash_ctl), 64'(8'hF1));
      check("reset data released", 64'((flash_data === 16'h0000) || (flash_data === 16'hzzzz)), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("ready after reset", 64'(req_ready), 64'd1);

      array_word = 16'hBEEF;
      run_cmd("read", 2'b00, 22'h000010, 16'h0000);
      check("read flash_addr", 64'(flash_addr), 64'(23'h000020));

      busy_reads = 3; busy_word = 16'h0000; final_status = 16'h0080;
      run_cmd("program", 2'b01, 22'h000003, 16'h1234);

      busy_reads = 1; busy_word = 16'h0001; final_status = 16'h00A0;
      er_addr = 22'h2A5A5A;
      run_cmd("erase", 2'b10, er_addr, 16'h0000);

      run_cmd("reserved", 2'b11, 22'h000777, 16'hFFFF);
      check("reserved flash_addr kept", 64'(flash_addr), 64'({er_addr, 1'b0}));

      busy_reads = 0; final_status = 16'h0080;
      req_valid = 1'b1; req_op = 2'b01; req_addr = 22'h000155; req_wdata = 16'h5A5A;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("abort we_n low before reset", 64'(flash_ctl[7]), 64'd0);
      r0  = rsp_total;
      rst = 1'b0;
      #1;
      check("abort we_n released", 64'(flash_ctl[7]), 64'd1);
      check("abort oe_n released", 64'(flash_ctl[4]), 64'd1);
      check("abort data released", 64'((flash_data === 16'h0000) || (flash_data === 16'hzzzz)), 64'd1);
      check("abort flash_addr", 64'(flash_addr), 64'd0);
      repeat (3) @(negedge clk);
      check("abort ready in reset", 64'(req_ready), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("abort ready after release", 64'(req_ready), 64'd1);
      check("abort no response", 64'(rsp_total - r0), 64'd0);

`ifdef FLASH_TIMEOUT_EN
      busy_reads = 100; busy_word = 16'h0000; final_status = 16'h0080;
      run_cmd("timeout", 2'b01, 22'h001234, 16'h4321);
`endif

      for (int n = 0; n < 10; n++) begin
         op           = 2'($urandom_range(0, 3));
         addr         = 22'($urandom);
         wd           = 16'($urandom);
         array_word   = 16'($urandom);
         busy_reads   = $urandom_range(0, 6);
         busy_word    = 16'($urandom) & 16'hFF7F;
         final_status = 16'($urandom) | 16'h0080;
         run_cmd($sformatf("rand%0d", n), op, addr, wd);
      end

      check("bus protocol", 64'(violations), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/flash_cmd_engine.md
FLASH_CMD_ENGINE -- requirements
Module: flash_cmd_engine

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 4, clocks each flash bus phase is held (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_POLLS, default 1023, max status polls before timeout (used only when FLASH_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  command request.
REQ-006 SHALL have port req_ready  output  1  engine can accept a command.
REQ-007 SHALL have port req_op  input  2  00 read, 01 program word, 10 block erase, 11 reserved.
REQ-008 SHALL have port req_addr  input  22  flash word address.
REQ-009 SHALL have port req_wdata  input  16  program data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  16  read data (read op); last status word (program/erase).
REQ-012 SHALL have port rsp_err  output  1  error flag, valid with rsp_valid.
REQ-013 SHALL have port flash_addr  output  23  byte address to device; bit 0 always 0, [22:1] = word address.
REQ-014 SHALL have port flash_data  inout  16  device data bus; high-Z except during write phases.
REQ-015 SHALL have port flash_ctl  output  8  {we_n, vpen, rp_n, oe_n, ce2, ce1, ce_n, byte_n} at bits [7:0].

Function
REQ-016 SHALL accept a command on a clock edge where req_valid and req_ready are both 1, latching op, addr, wdata; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL hold byte_n=1, ce1=0, ce2=0, rp_n=1, vpen=1, ce_n=0 constantly; only we_n, oe_n, flash_addr, flash_data vary.
REQ-018 SHALL build every device write as WR_LOW (we_n=0, data driven, WAIT_CYCLES clocks) then WR_HIGH (we_n=1, data still driven, WAIT_CYCLES clocks).
REQ-019 SHALL build every device read as RD (oe_n=0, data high-Z, WAIT_CYCLES clocks), sampling flash_data on the last clock of RD, then RD_GAP (oe_n=1, 1 clock).
REQ-020 Read op SHALL issue write 0x00FF at req_addr, then read at req_addr, then pulse rsp_valid with rsp_rdata = sampled word, rsp_err=0.
REQ-021 Program op SHALL issue write 0x0040, then write req_wdata, then status poll; all at req_addr.
REQ-022 Erase op SHALL issue write 0x0020, then write 0x00D0, then status poll; all at req_addr.
REQ-023 Status poll SHALL issue write 0x0070 once, then repeat reads until sampled bit 7 = 1.
REQ-024 On poll completion SHALL set rsp_rdata = status word, rsp_err = OR of status bits 5,4,3,1, then issue write 0x00FF before pulsing rsp_valid.
REQ-025 Reserved op 11 SHALL touch no bus signal and pulse rsp_valid with rsp_err=1, rsp_rdata=0 on the cycle after acceptance.
REQ-026 rsp_valid SHALL be high exactly one clock, coinciding with return to IDLE; req_ready SHALL rise the following clock.
REQ-027 Phase counter SHALL be 4 bits, reload WAIT_CYCLES-1 on phase entry, advance phase when it reaches 0.
REQ-028 Outside write phases flash_data SHALL be high-Z; we_n and oe_n SHALL never be 0 simultaneously.
REQ-029 req_valid while busy SHALL be ignored without effect on the active command.

Reset
REQ-030 Asserting rst (0) SHALL immediately force IDLE, req_ready=0 while asserted, rsp_valid=0, rsp_err=0, rsp_rdata=0, flash_addr=0, we_n=1, oe_n=1, flash_data high-Z.
REQ-031 Reset mid-command SHALL abort without a response; req_ready SHALL be 1 on the first clock after rst deasserts.

Configuration
REQ-032 With FLASH_TIMEOUT_EN defined, a 10-bit poll counter SHALL end polling after TIMEOUT_POLLS reads without bit 7, completing per REQ-024 with rsp_err=1 and rsp_rdata = last status.
REQ-033 Without FLASH_TIMEOUT_EN, polling SHALL continue indefinitely and no poll counter SHALL exist.

Verification
REQ-034 Read op, addr 0x000010, flash model word 0xBEEF -> 0xFF write then oe_n low WAIT_CYCLES clocks, flash_addr=0x000020, rsp_valid pulse with rdata 0xBEEF, err 0.
REQ-035 Program op, addr 0x3, data 0x1234, model status 0x0080 after 3 polls -> writes 0x40, 0x1234, 0x70, four reads, 0xFF, rsp_rdata 0x0080, err 0.
REQ-036 Erase op, model status 0x00A0 -> writes 0x20, 0xD0, 0x70, rsp_err=1, rsp_rdata 0x00A0.
REQ-037 Op 11 -> no we_n/oe_n activity, rsp_valid one cycle after acceptance with err 1.
REQ-038 rst low during program WR_LOW -> we_n=1, flash_data high-Z same cycle, no rsp_valid, req_ready=1 first clock after release.
REQ-039 FLASH_TIMEOUT_EN, TIMEOUT_POLLS=5, status stuck 0x0000 -> exactly 5 status reads, then 0xFF write, rsp_err=1.
